// File: rtl/calc_pkg.sv
// Shared constants for the calculator key-entry path: key codes, digit limits,
// value scaling, entry state encoding and small arithmetic helpers.
package calc_pkg;

    localparam int DATA_W = 25;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
    localparam logic [3:0] KEY_POINT     = 4'd10;
    localparam logic [3:0] KEY_MINUS     = 4'd11;
    localparam logic [3:0] KEY_CLEAR     = 4'd12;
    localparam logic [3:0] KEY_ENTER     = 4'd13;

    localparam logic [2:0] INT_MAX       = 3'd4;
    localparam logic [2:0] FRAC_MAX      = 3'd3;
    localparam logic [2:0] SHOWN_MAX_POS = 3'd4;
    localparam logic [2:0] SHOWN_MAX_NEG = 3'd3;

    // Place weights of the stored fixed-point value (value x1000).
    localparam logic [9:0] SCALE  = 10'd1000;
    localparam logic [9:0] W_FRAC1 = 10'd100;
    localparam logic [9:0] W_FRAC2 = 10'd10;
    localparam logic [9:0] W_FRAC3 = 10'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INT  = 2'd1,
        ST_FRAC = 2'd2,
        ST_DONE = 2'd3
    } entry_state_e;

    // Digit times a small constant weight, built from shifts and adds only.
    function automatic logic [DATA_W-1:0] mul_const(input logic [3:0] d, input logic [9:0] w);
        logic [DATA_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < 10; i++) begin
            if (w[i]) acc = acc + ({{(DATA_W-4){1'b0}}, d} << i);
        end
        return acc;
    endfunction

    // Display digits in use: at least one integer digit is always shown.
    function automatic logic [2:0] shown_digits(input logic [2:0] int_cnt, input logic [2:0] frac_cnt);
        return ((int_cnt == 3'd0) ? 3'd1 : int_cnt) + frac_cnt;
    endfunction

endpackage

// File: rtl/entry_accum.sv
// Combinational digit accumulator: pos 0 appends an integer digit (x10 + d*1000),
// pos 1..3 adds a fraction digit at weight 100/10/1.
module entry_accum
    import calc_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [3:0]        digit,
    input  logic [1:0]        pos,
    output logic [DATA_W-1:0] next_data
);

    logic [DATA_W-1:0] data_x10;

    assign data_x10 = (data << 3) + (data << 1);

    always_comb begin
        next_data = data;
        case (pos)
            2'd0:    next_data = data_x10 + mul_const(digit, SCALE);
            2'd1:    next_data = data + mul_const(digit, W_FRAC1);
            2'd2:    next_data = data + mul_const(digit, W_FRAC2);
            default: next_data = data + mul_const(digit, W_FRAC3);
        endcase
    end

endmodule

// File: rtl/key_entry.sv
// Keypad number entry: accumulates a signed fixed-point value (x1000) from key
// strobes, enforcing the display digit budget.
//
// state   | meaning
// IDLE    | nothing entered (or only a sign / leading zeros)
// INT     | integer digits being entered
// FRAC    | decimal point seen, fraction digits being entered
// DONE    | value committed by enter; next edit key starts a fresh entry
module key_entry
    import calc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    output logic [DATA_W-1:0] data,
    output logic              neg,
    output logic              frac,
    output logic              error,
    output logic              done
);

    entry_state_e      state, state_nxt, eff_state;
    logic [DATA_W-1:0] data_nxt, eff_data, accum_data;
    logic              neg_nxt, frac_nxt, error_nxt, done_nxt;
    logic              eff_neg, eff_frac_flag, eff_error;
    logic [2:0]        int_cnt, int_nxt, eff_int, new_int;
    logic [1:0]        frac_cnt, frac_cnt_nxt, eff_frac;
    logic [2:0]        new_frac, shown, new_shown, limit;
    logic [1:0]        accum_pos;
    logic              is_digit, restart, lead_zero, digit_ok;

    // A new edit key after enter behaves as if clear had been pressed first.
    always_comb begin
        is_digit      = (key_code <= KEY_DIGIT_MAX);
        restart       = (state == ST_DONE) &&
                        (is_digit || key_code == KEY_POINT || key_code == KEY_MINUS);
        eff_state     = restart ? ST_IDLE : state;
        eff_data      = restart ? '0 : data;
        eff_neg       = restart ? 1'b0 : neg;
        eff_frac_flag = restart ? 1'b0 : frac;
        eff_error     = restart ? 1'b0 : error;
        eff_int       = restart ? 3'd0 : int_cnt;
        eff_frac      = restart ? 2'd0 : frac_cnt;

        limit     = eff_neg ? SHOWN_MAX_NEG : SHOWN_MAX_POS;
        shown     = shown_digits(eff_int, {1'b0, eff_frac});
        lead_zero = (eff_data == '0) && (key_code == 4'd0);
        new_int   = lead_zero ? eff_int : eff_int + 3'd1;
        new_frac  = {1'b0, eff_frac} + 3'd1;

        if (eff_state == ST_FRAC) begin
            accum_pos = eff_frac + 2'd1;
            new_shown = shown_digits(eff_int, new_frac);
            digit_ok  = (new_frac <= FRAC_MAX) && (new_shown <= limit);
        end else begin
            accum_pos = 2'd0;
            new_shown = shown_digits(new_int, {1'b0, eff_frac});
            digit_ok  = (new_int <= INT_MAX) && (new_shown <= limit);
        end
    end

    entry_accum u_accum (
        .data      (eff_data),
        .digit     (key_code),
        .pos       (accum_pos),
        .next_data (accum_data)
    );

    always_comb begin
        state_nxt    = state;
        data_nxt     = data;
        neg_nxt      = neg;
        frac_nxt     = frac;
        error_nxt    = error;
        int_nxt      = int_cnt;
        frac_cnt_nxt = frac_cnt;
        done_nxt     = 1'b0;

        if (key_valid) begin
            state_nxt    = eff_state;
            data_nxt     = eff_data;
            neg_nxt      = eff_neg;
            frac_nxt     = eff_frac_flag;
            error_nxt    = eff_error;
            int_nxt      = eff_int;
            frac_cnt_nxt = eff_frac;

            if (is_digit) begin
                if (!digit_ok) begin
                    error_nxt = 1'b1;
                end else if (eff_state == ST_FRAC) begin
                    data_nxt     = accum_data;
                    frac_cnt_nxt = new_frac[1:0];
                end else begin
                    data_nxt  = accum_data;
                    int_nxt   = new_int;
                    state_nxt = ST_INT;
                end
            end else begin
                case (key_code)
                    KEY_POINT: begin
                        if (eff_state != ST_FRAC) begin
                            frac_nxt  = 1'b1;
                            state_nxt = ST_FRAC;
                        end
                    end
                    KEY_MINUS: begin
                        // Going negative costs a display digit for the sign.
                        if (eff_neg || shown <= SHOWN_MAX_NEG) neg_nxt = ~eff_neg;
                        else error_nxt = 1'b1;
                    end
                    KEY_CLEAR: begin
                        state_nxt    = ST_IDLE;
                        data_nxt     = '0;
                        neg_nxt      = 1'b0;
                        frac_nxt     = 1'b0;
                        error_nxt    = 1'b0;
                        int_nxt      = 3'd0;
                        frac_cnt_nxt = 2'd0;
                    end
                    KEY_ENTER: begin
                        if (state != ST_DONE) begin
                            done_nxt  = 1'b1;
                            state_nxt = ST_DONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            data     <= '0;
            neg      <= 1'b0;
            frac     <= 1'b0;
            error    <= 1'b0;
            done     <= 1'b0;
            int_cnt  <= 3'd0;
            frac_cnt <= 2'd0;
        end else begin
            state    <= state_nxt;
            data     <= data_nxt;
            neg      <= neg_nxt;
            frac     <= frac_nxt;
            error    <= error_nxt;
            done     <= done_nxt;
            int_cnt  <= int_nxt;
            frac_cnt <= frac_cnt_nxt;
        end
    end

endmodule

// File: doc/key_entry.md
KEY_ENTRY -- requirements
Module: key_entry

Interface
REQ-001 clk  in  1  rising-edge system clock.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 key_valid  in  1  one-cycle strobe; key_code sampled when high; back-to-back strobes legal.
REQ-004 key_code  in  4  0-9 digit, 10 decimal point, 11 minus (sign toggle), 12 clear, 13 enter, 14-15 ignored.
REQ-005 data  out  25  unsigned magnitude of entered value x1000 (max 9_999_999); feeds display formatter.
REQ-006 neg  out  1  entered value is negative.
REQ-007 frac  out  1  decimal point has been entered.
REQ-008 error  out  1  sticky: a key was rejected by a digit limit.
REQ-009 done  out  1  one-cycle pulse when enter is accepted.

Function
REQ-010 All outputs registered; key effect visible on outputs the cycle after the key_valid sample; no other latency.
REQ-011 States: IDLE (nothing entered), INT, FRAC, DONE; state, digit counters and outputs change only on key_valid or reset.
REQ-012 Counters: int_cnt = significant integer digits (0-4), frac_cnt = fraction digits (0-3); shown = max(int_cnt,1)+frac_cnt.
REQ-013 Limits: neg=0 -> int_cnt<=4, frac_cnt<=3, shown<=4; neg=1 -> shown<=3 (minus sign occupies one display digit).
REQ-014 Digit d in IDLE/INT: data <= data*10 + d*1000; int_cnt increments unless data was 0 (leading zero: data stays 0, int_cnt stays 0); state INT.
REQ-015 Digit d in FRAC: data <= data + d*{100,10,1} for frac_cnt={0,1,2}; frac_cnt increments, trailing zeros included.
REQ-016 Digit violating REQ-013: data and counters unchanged, error <= 1.
REQ-017 Decimal point in IDLE/INT: frac <= 1, state FRAC, data unchanged; in FRAC: ignored, no error.
REQ-018 Minus: toggles neg if result satisfies REQ-013; otherwise neg unchanged, error <= 1; legal in IDLE/INT/FRAC.
REQ-019 Clear: data, neg, frac, error, counters <= 0; state IDLE; allowed in every state.
REQ-020 Enter in IDLE/INT/FRAC: done <= 1 for exactly one cycle, state DONE, value held; enter in DONE ignored.
REQ-021 In DONE: digit or decimal point first clears (REQ-019), then applies as in IDLE in the same cycle; minus clears then sets neg=1.
REQ-022 Codes 14-15: ignored, no state or output change.
REQ-023 error clears only on clear key or reset; error does not block further accepted keys.
REQ-024 data never exceeds 9_999_999; no wrap-around under any key sequence.

Reset
REQ-025 rst_n low: data=0, neg=0, frac=0, error=0, done=0, counters=0, state IDLE, immediately, regardless of clk.
REQ-026 Reset mid-entry discards the partial value; first key after release is treated as in IDLE.

Structure
REQ-027 Key-code constants, digit limits (4/3/4/3), 1000 scale factor and state encoding SHALL live in shared package calc_pkg.
REQ-028 One sub-module: entry_accum, combinational; inputs data, digit, position (int/frac index); outputs next data via shift-and-add multiply-by-10 and d*{1000,100,10,1} scaling, no divider.
REQ-029 No division or modulo operators in this block.

Verification
REQ-030 Keys 1,2,3,4,5 -> after 4th: data=1_234_000, frac=0; 5th rejected, data unchanged, error=1.
REQ-031 Keys 3,.,1,4,1,5 -> data=3_141, frac=1; key 5 rejected (shown=4 after 1), error=1.
REQ-032 Keys minus,1,2,3,4 -> neg=1, data=123_000; 4 rejected, error=1; then clear -> all outputs 0.
REQ-033 Keys 1,2,3,4,minus -> neg stays 0, error=1; keys 0,0,7 from IDLE -> data=7_000, int_cnt=1.
REQ-034 Keys 5,enter,enter,8 -> done high exactly one cycle after first enter only; after 8: data=8_000, neg=0, frac=0.
REQ-035 Keys 9,.,9 then rst_n low mid-cycle -> outputs 0 asynchronously; after release, key 2 -> data=2_000.
